// File: rtl/bus_datapath_core.sv
// Single-bus CPU datapath: register file, special registers, priority bus mux
// with conflict detection, and an ALU with an iterative shift-add multiplier.
module bus_datapath_core #(
    parameter int DATA_W  = 32,
    parameter int NUM_GPR = 16,
    parameter int IMM_W   = 18
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NUM_GPR+7:0]   src_en,
    input  logic [NUM_GPR+7:0]   dst_en,
    input  logic                 z_in,
    input  logic [2:0]           alu_op,
    input  logic                 mdr_read,
    input  logic [DATA_W-1:0]    mem_data_in,
    input  logic                 inport_strobe,
    input  logic [DATA_W-1:0]    inport_data,
    output logic [DATA_W-1:0]    bus_data,
    output logic [DATA_W-1:0]    mar_out,
    output logic [DATA_W-1:0]    mdr_out,
    output logic [DATA_W-1:0]    outport_out,
    output logic [DATA_W-1:0]    ir_out,
    output logic                 bus_conflict,
    output logic                 bus_err,
    output logic                 mul_busy,
    output logic                 mul_done
);

    localparam int SRC_W = NUM_GPR + 8;
    localparam int POP_W = $clog2(SRC_W + 1);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);

    localparam int S_HI  = NUM_GPR + 0;
    localparam int S_LO  = NUM_GPR + 1;
    localparam int S_ZHI = NUM_GPR + 2;
    localparam int S_ZLO = NUM_GPR + 3;
    localparam int S_PC  = NUM_GPR + 4;
    localparam int S_MDR = NUM_GPR + 5;
    localparam int S_IN  = NUM_GPR + 6;
    localparam int S_C   = NUM_GPR + 7;

    localparam int D_PC  = NUM_GPR + 0;
    localparam int D_IR  = NUM_GPR + 1;
    localparam int D_Y   = NUM_GPR + 2;
    localparam int D_HI  = NUM_GPR + 3;
    localparam int D_LO  = NUM_GPR + 4;
    localparam int D_MAR = NUM_GPR + 5;
    localparam int D_MDR = NUM_GPR + 6;
    localparam int D_OUT = NUM_GPR + 7;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SHL = 3'd4,
        OP_SHR = 3'd5,
        OP_NOT = 3'd6,
        OP_MUL = 3'd7
    } alu_op_t;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } mul_state_t;

    logic [DATA_W-1:0] gpr [NUM_GPR];
    logic [DATA_W-1:0] pc_q, ir_q, y_q, hi_q, lo_q, mar_q, mdr_q, inport_q, outport_q;
    logic [DATA_W-1:0] zhi_q, zlo_q;

    logic [DATA_W-1:0] src_val [SRC_W];
    logic [DATA_W-1:0] bus;
    logic              found;
    logic [POP_W-1:0]  pop;

    alu_op_t           op;
    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] alu_hi, alu_lo;

    mul_state_t          state_q, state_d;
    logic [2*DATA_W-1:0] mul_a_q, acc_q, acc_next;
    logic [DATA_W-1:0]   mul_b_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                mul_start, mul_last, alu_wr, mul_done_q, bus_err_q;

    // Bus sources
    always_comb begin
        for (int unsigned i = 0; i < NUM_GPR; i++) begin
            src_val[i] = gpr[i];
        end
        src_val[S_HI]  = hi_q;
        src_val[S_LO]  = lo_q;
        src_val[S_ZHI] = zhi_q;
        src_val[S_ZLO] = zlo_q;
        src_val[S_PC]  = pc_q;
        src_val[S_MDR] = mdr_q;
        src_val[S_IN]  = inport_q;
        src_val[S_C]   = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
    end

    // Lowest enabled index wins; the population count flags contention.
    always_comb begin
        bus   = '0;
        found = 1'b0;
        pop   = '0;
        for (int unsigned i = 0; i < SRC_W; i++) begin
            if (src_en[i] && !found) begin
                bus   = src_val[i];
                found = 1'b1;
            end
            pop = pop + POP_W'(src_en[i]);
        end
    end

    assign bus_data     = bus;
    assign bus_conflict = (pop > POP_W'(1));

    // ALU: A = Y, B = bus
    assign op   = alu_op_t'(alu_op);
    assign sum  = {1'b0, y_q} + {1'b0, bus};
    assign diff = {1'b0, y_q} - {1'b0, bus};

    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        case (op)
            OP_ADD: begin
                alu_lo = sum[DATA_W-1:0];
                alu_hi = {{(DATA_W-1){1'b0}}, sum[DATA_W]};
            end
            OP_SUB: begin
                alu_lo = diff[DATA_W-1:0];
                alu_hi = {{(DATA_W-1){1'b0}}, diff[DATA_W]};
            end
            OP_AND:  alu_lo = y_q & bus;
            OP_OR:   alu_lo = y_q | bus;
            OP_SHL:  alu_lo = y_q << bus[SH_W-1:0];
            OP_SHR:  alu_lo = y_q >> bus[SH_W-1:0];
            OP_NOT:  alu_lo = ~bus;
            default: alu_lo = '0;
        endcase
    end

    assign mul_start = (state_q == IDLE) && z_in && (op == OP_MUL);
    assign alu_wr    = (state_q == IDLE) && z_in && (op != OP_MUL);
    assign mul_last  = (state_q == MUL_RUN) && (cnt_q == '0);
    assign acc_next  = acc_q + (mul_b_q[0] ? mul_a_q : '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mul_start) state_d = MUL_RUN;
            MUL_RUN: if (mul_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured at start, so Y/bus activity during a multiply is harmless.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            zhi_q      <= '0;
            zlo_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mul_done_q <= 1'b0;
        end else begin
            mul_done_q <= mul_last;
            if (alu_wr) begin
                zhi_q <= alu_hi;
                zlo_q <= alu_lo;
            end
            if (mul_start) begin
                mul_a_q <= {{DATA_W{1'b0}}, y_q};
                mul_b_q <= bus;
                acc_q   <= '0;
                cnt_q   <= CNT_W'(DATA_W - 1);
            end else if (state_q == MUL_RUN) begin
                acc_q   <= acc_next;
                mul_a_q <= mul_a_q << 1;
                mul_b_q <= mul_b_q >> 1;
                cnt_q   <= cnt_q - 1'b1;
                if (mul_last) begin
                    {zhi_q, zlo_q} <= acc_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int unsigned i = 0; i < NUM_GPR; i++) begin
                gpr[i] <= '0;
            end
            pc_q      <= '0;
            ir_q      <= '0;
            y_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_GPR; i++) begin
                if (dst_en[i]) gpr[i] <= bus;
            end
            if (dst_en[D_PC])  pc_q      <= bus;
            if (dst_en[D_IR])  ir_q      <= bus;
            if (dst_en[D_Y])   y_q       <= bus;
            if (dst_en[D_HI])  hi_q      <= bus;
            if (dst_en[D_LO])  lo_q      <= bus;
            if (dst_en[D_MAR]) mar_q     <= bus;
            if (dst_en[D_MDR]) mdr_q     <= mdr_read ? mem_data_in : bus;
            if (dst_en[D_OUT]) outport_q <= bus;
            if (inport_strobe) inport_q  <= inport_data;
            bus_err_q <= bus_err_q | bus_conflict;
        end
    end

    assign mar_out     = mar_q;
    assign mdr_out     = mdr_q;
    assign outport_out = outport_q;
    assign ir_out      = ir_q;
    assign bus_err     = bus_err_q;
    assign mul_busy    = (state_q == MUL_RUN);
    assign mul_done    = mul_done_q;

endmodule

// File: tb/tb_bus_datapath_core.sv
// Directed testbench for bus_datapath_core with hand-computed expectations.
module tb_bus_datapath_core;

    localparam int NG = 16;
    localparam int W  = NG + 8;

    localparam int S_ZHI = NG + 2, S_ZLO = NG + 3, S_PC = NG + 4, S_IN = NG + 6, S_C = NG + 7;
    localparam int D_PC = NG + 0, D_IR = NG + 1, D_Y = NG + 2, D_MAR = NG + 5, D_MDR = NG + 6, D_OUT = NG + 7;

    logic          clk = 1'b0;
    logic          clr;
    logic [W-1:0]  src_en, dst_en;
    logic          z_in, mdr_read, inport_strobe;
    logic [2:0]    alu_op;
    logic [31:0]   mem_data_in, inport_data;
    logic [31:0]   bus_data, mar_out, mdr_out, outport_out, ir_out;
    logic          bus_conflict, bus_err, mul_busy, mul_done;

    int n_tests = 0;
    int n_fail  = 0;

    bus_datapath_core #(.DATA_W(32), .NUM_GPR(NG), .IMM_W(18)) dut (
        .clk(clk), .clr(clr), .src_en(src_en), .dst_en(dst_en), .z_in(z_in),
        .alu_op(alu_op), .mdr_read(mdr_read), .mem_data_in(mem_data_in),
        .inport_strobe(inport_strobe), .inport_data(inport_data),
        .bus_data(bus_data), .mar_out(mar_out), .mdr_out(mdr_out),
        .outport_out(outport_out), .ir_out(ir_out), .bus_conflict(bus_conflict),
        .bus_err(bus_err), .mul_busy(mul_busy), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_en = '0; dst_en = '0; z_in = 1'b0; alu_op = 3'd0;
        mdr_read = 1'b0; inport_strobe = 1'b0;
    endtask

    task automatic set_inport(input logic [31:0] v);
        inport_data = v; inport_strobe = 1'b1;
        tick();
        inport_strobe = 1'b0;
    endtask

    task automatic load_reg(input int dst, input logic [31:0] v);
        set_inport(v);
        src_en = '0; dst_en = '0;
        src_en[S_IN] = 1'b1; dst_en[dst] = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic read_src(input int src, output logic [31:0] v);
        src_en = '0; src_en[src] = 1'b1;
        #1 v = bus_data;
        src_en = '0;
    endtask

    // Y must already hold A; B goes over the bus from INPORT.
    task automatic alu_run(input logic [2:0] op, input logic [31:0] b);
        set_inport(b);
        src_en = '0; src_en[S_IN] = 1'b1; z_in = 1'b1; alu_op = op;
        tick();
        idle_inputs();
    endtask

    logic [31:0] v;
    int busy_cycles, done_cycle, done_count;

    initial begin
        idle_inputs();
        mem_data_in = '0; inport_data = '0;
        clr = 1'b0;
        repeat (3) tick();
        check("rst_mar", mar_out, 32'h0);
        check("rst_mdr", mdr_out, 32'h0);
        check("rst_out", outport_out, 32'h0);
        check("rst_ir", ir_out, 32'h0);
        check("rst_flags", {28'h0, bus_err, mul_busy, mul_done, bus_conflict}, 32'h0);
        check("rst_bus_idle", bus_data, 32'h0);
        clr = 1'b1;
        tick();

        // 1: INPORT -> R3 -> bus
        load_reg(3, 32'h0000_1234);
        src_en = '0; src_en[3] = 1'b1;
        #1;
        check("r3_bus", bus_data, 32'h0000_1234);
        check("r3_conflict", {31'h0, bus_conflict}, 32'h0);
        tick();
        src_en = '0;
        check("r3_bus_err", {31'h0, bus_err}, 32'h0);

        // 2: R1 and PC both driving; R1 wins, conflict flagged and made sticky
        load_reg(1, 32'd5);
        load_reg(D_PC, 32'd9);
        read_src(S_PC, v);
        check("pc_val", v, 32'd9);
        src_en = '0; src_en[1] = 1'b1; src_en[S_PC] = 1'b1;
        #1;
        check("prio_bus", bus_data, 32'd5);
        check("prio_conflict", {31'h0, bus_conflict}, 32'h1);
        check("err_before_edge", {31'h0, bus_err}, 32'h0);
        tick();
        src_en = '0;
        check("err_after_edge", {31'h0, bus_err}, 32'h1);
        src_en[1] = 1'b1; dst_en[D_OUT] = 1'b1; dst_en[D_MAR] = 1'b1;
        tick();
        idle_inputs();
        check("outport", outport_out, 32'd5);
        check("mar", mar_out, 32'd5);
        check("err_sticky", {31'h0, bus_err}, 32'h1);

        // 3: sign-extended immediate, ADD with carry
        load_reg(D_IR, 32'h0002_0001);
        check("ir", ir_out, 32'h0002_0001);
        read_src(S_C, v);
        check("imm_c", v, 32'hFFFE_0001);
        load_reg(D_Y, 32'hFFFF_FFFF);
        alu_run(3'd0, 32'h1);
        read_src(S_ZLO, v); check("add_zlo", v, 32'h0);
        read_src(S_ZHI, v); check("add_zhi", v, 32'h1);

        // 4: SUB with borrow, shifts, logic ops
        load_reg(D_Y, 32'd3);
        alu_run(3'd1, 32'd5);
        read_src(S_ZLO, v); check("sub_zlo", v, 32'hFFFF_FFFE);
        read_src(S_ZHI, v); check("sub_zhi", v, 32'h1);
        load_reg(D_Y, 32'h8000_0001);
        alu_run(3'd5, 32'd4);
        read_src(S_ZLO, v); check("shr_zlo", v, 32'h0800_0000);
        read_src(S_ZHI, v); check("shr_zhi", v, 32'h0);
        load_reg(D_Y, 32'h0000_F0F0);
        alu_run(3'd2, 32'h0000_FF00);
        read_src(S_ZLO, v); check("and_zlo", v, 32'h0000_F000);
        alu_run(3'd6, 32'h0000_FF00);
        read_src(S_ZLO, v); check("not_zlo", v, 32'hFFFF_00FF);
        load_reg(D_Y, 32'd1);
        alu_run(3'd4, 32'h23);
        read_src(S_ZLO, v); check("shl_zlo", v, 32'h8);

        // 5: MUL 0xFFFFFFFF * 0xFFFFFFFF with disturbances during the run
        load_reg(D_Y, 32'hFFFF_FFFF);
        alu_run(3'd7, 32'hFFFF_FFFF);
        busy_cycles = 0; done_cycle = 0; done_count = 0;
        for (int c = 1; c <= 40; c++) begin
            if (mul_busy) busy_cycles++;
            if (mul_done) begin
                if (done_cycle == 0) done_cycle = c;
                done_count++;
            end
            if (c == 5)  begin src_en[3] = 1'b1; dst_en[D_Y] = 1'b1; end
            if (c == 10) begin src_en[S_IN] = 1'b1; z_in = 1'b1; alu_op = 3'd0; end
            if (c == 15) begin src_en[1] = 1'b1; dst_en[2] = 1'b1; end
            if (c == 20) begin
                src_en[S_ZLO] = 1'b1;
                #1 check("mul_z_hold", bus_data, 32'h8);
            end
            tick();
            idle_inputs();
        end
        check("mul_busy_cycles", busy_cycles, 32'd32);
        check("mul_done_cycle", done_cycle, 32'd33);
        check("mul_done_count", done_count, 32'd1);
        read_src(S_ZHI, v); check("mul_zhi", v, 32'hFFFF_FFFE);
        read_src(S_ZLO, v); check("mul_zlo", v, 32'h0000_0001);
        read_src(2, v);     check("r2_during_mul", v, 32'd5);

        // 6: abort mid-multiply with reset
        alu_run(3'd7, 32'hFFFF_FFFF);
        for (int c = 1; c < 12; c++) tick();
        check("abort_busy_pre", {31'h0, mul_busy}, 32'h1);
        clr = 1'b0;
        #1;
        check("abort_busy", {31'h0, mul_busy}, 32'h0);
        tick();
        clr = 1'b1;
        done_count = 0;
        for (int c = 0; c < 40; c++) begin
            if (mul_done) done_count++;
            tick();
        end
        check("abort_no_done", done_count, 32'd0);
        read_src(S_ZHI, v); check("abort_zhi", v, 32'h0);
        read_src(S_ZLO, v); check("abort_zlo", v, 32'h0);
        check("abort_err_clr", {31'h0, bus_err}, 32'h0);

        mem_data_in = 32'hCAFE_BABE;
        mdr_read = 1'b1; dst_en[D_MDR] = 1'b1;
        tick();
        idle_inputs();
        check("mdr_mem", mdr_out, 32'hCAFE_BABE);
        load_reg(D_MDR, 32'h1357_9BDF);
        check("mdr_bus", mdr_out, 32'h1357_9BDF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
